cmp_frame_minmax: RTL and testbench

//  Streaming signed min/max tracker that sits around the subtract-based comparator.
//  - Drives the comparator's X/Y operands.
//  - Consumes its V/N/Z flags to keep a running min and max over a frame of samples.
//  - Emits {min,max,count} with a valid/ready handshake when the frame ends.
//  One comparator is shared: the max-compare and the min-compare of each sample take one cycle each.

---
 rtl/cmp_frame_minmax_pkg.sv | 24 ++
 rtl/cmp_frame_minmax_if.sv | 29 ++
 rtl/cmp_sub.sv | 21 ++
 rtl/cmp_frame_minmax.sv | 111 +++++++++++
 tb/tb_cmp_frame_minmax.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cmp_frame_minmax_pkg.sv
// Shared types and comparator-flag decode for the frame min/max tracker.
`default_nettype none

package cmp_pkg;

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_CMPMAX = 2'd1,
    S_CMPMIN = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // X<Y signed: the sign of X-Y is wrong exactly when the subtraction overflowed
  function automatic logic signed_lt(input logic v, input logic n);
    return n ^ v;
  endfunction

  function automatic logic signed_gt(input logic v, input logic n, input logic z);
    return ~z & ~(n ^ v);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmp_frame_minmax_if.sv
// Sample-in / result-out handshake bundle for cmp_frame_minmax.
`default_nettype none

interface cmp_frame_minmax_if #(
  parameter int N  = 32,
  parameter int CW = 16
);
  logic          in_valid;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_min;
  logic [N-1:0]  out_max;
  logic [CW-1:0] out_count;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );
endinterface

`default_nettype wire

// File: rtl/cmp_sub.sv
// Subtract-based signed comparator: flags of X-Y (overflow, negative, zero).
`default_nettype none

module cmp_sub #(
  parameter int N = 32
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         v,
  output logic         n,
  output logic         z
);
  logic [N-1:0] diff;

  assign diff = x - y;
  assign n    = diff[N-1];
  assign z    = (diff == '0);
  assign v    = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
endmodule

`default_nettype wire

// File: rtl/cmp_frame_minmax.sv
// Streaming signed min/max tracker over a frame, sharing one external comparator
// between the max-compare and min-compare of each sample.
`default_nettype none

module cmp_frame_minmax
  import cmp_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  cmp_frame_minmax_if.slave     st,
  output logic [N-1:0]          cmp_x,
  output logic [N-1:0]          cmp_y,
  input  logic                  cmp_v,
  input  logic                  cmp_n,
  input  logic                  cmp_z
);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nxt;
  logic [N-1:0]  sample_q, sample_nxt;
  logic [N-1:0]  min_q, min_nxt;
  logic [N-1:0]  max_q, max_nxt;
  logic [CW-1:0] count_q, count_nxt;
  logic          last_q, last_nxt;
  logic          in_ready, out_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
      min_q    <= '0;
      max_q    <= '0;
      count_q  <= '0;
      last_q   <= 1'b0;
    end else begin
      sample_q <= sample_nxt;
      min_q    <= min_nxt;
      max_q    <= max_nxt;
      count_q  <= count_nxt;
      last_q   <= last_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    sample_nxt = sample_q;
    min_nxt    = min_q;
    max_nxt    = max_q;
    count_nxt  = count_q;
    last_nxt   = last_q;
    cmp_y      = '0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      S_WAIT: begin
        in_ready = 1'b1;
        if (st.in_valid) begin
          if (count_q == '0) begin
            // First sample seeds both extremes, no compare needed
            min_nxt   = st.in_data;
            max_nxt   = st.in_data;
            count_nxt = CW'(1);
            if (st.in_last) state_nxt = S_DONE;
          end else begin
            sample_nxt = st.in_data;
            last_nxt   = st.in_last;
            if (count_q != CNT_MAX) count_nxt = count_q + CW'(1);
            state_nxt  = S_CMPMAX;
          end
        end
      end
      S_CMPMAX: begin
        cmp_y = max_q;
        if (signed_gt(cmp_v, cmp_n, cmp_z)) max_nxt = sample_q;
        state_nxt = S_CMPMIN;
      end
      S_CMPMIN: begin
        cmp_y = min_q;
        if (signed_lt(cmp_v, cmp_n)) min_nxt = sample_q;
        state_nxt = last_q ? S_DONE : S_WAIT;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (st.out_ready) begin
          count_nxt = '0;
          state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_WAIT;
    endcase
  end

  assign cmp_x        = sample_q;
  assign st.in_ready  = in_ready;
  assign st.out_valid = out_valid;
  assign st.out_min   = min_q;
  assign st.out_max   = max_q;
  assign st.out_count = count_q;
endmodule

`default_nettype wire

// File: tb/tb_cmp_frame_minmax.sv
// Bench for cmp_frame_minmax with the subtract comparator attached (N=8, CW=4).
`default_nettype none

module tb_cmp_frame_minmax;
  localparam int N  = 8;
  localparam int CW = 4;

  logic clk;
  logic reset_n;
  logic [N-1:0] cmp_x, cmp_y;
  logic cmp_v, cmp_n, cmp_z;

  cmp_frame_minmax_if #(.N(N), .CW(CW)) bus ();

  cmp_frame_minmax #(.N(N), .CW(CW)) dut (
    .clk(clk), .reset_n(reset_n), .st(bus),
    .cmp_x(cmp_x), .cmp_y(cmp_y), .cmp_v(cmp_v), .cmp_n(cmp_n), .cmp_z(cmp_z)
  );

  cmp_sub #(.N(N)) u_cmp (
    .x(cmp_x), .y(cmp_y), .v(cmp_v), .n(cmp_n), .z(cmp_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  typedef struct {
    string      name;
    int         first;
    int         len;
    logic [7:0] emin;
    logic [7:0] emax;
    int         ecount;
  } vec_t;

  logic [7:0] pool[$];
  vec_t       vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic [7:0] emin, input logic [7:0] emax,
                            input int ecount, input int odelay);
    int t = 0;
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_min"},   32'(bus.out_min),   32'(emin));
    chk({nm, "_max"},   32'(bus.out_max),   32'(emax));
    chk({nm, "_count"}, 32'(bus.out_count), 32'(ecount));
    repeat (odelay) @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({nm, "_drop"}, 32'(bus.out_valid), 32'd0);
  endtask

  // Drives a whole frame and checks result latency after the last sample
  task automatic run_frame(input string nm, input logic [7:0] q[$], input logic [7:0] emin,
                           input logic [7:0] emax, input int ecount, input int odelay);
    int lat = 0;
    for (int i = 0; i < q.size(); i++) send(q[i], (i == q.size() - 1));
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({nm, "_latency"}, 32'(lat), (q.size() == 1) ? 32'd0 : 32'd2);
    get_result(nm, emin, emax, ecount, odelay);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] d;
    int mn, mx, len;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    reset_n       = 1'b0;

    pool = '{8'd5, 8'hFD, 8'd12, 8'd0, 8'd7, 8'h7F, 8'h80, 8'h80, 8'h7F};
    for (int i = 0; i <= 16; i++) pool.push_back(8'(i));
    vecs.push_back('{"frame_a",   0, 4,  8'hFD, 8'h0C, 4});
    vecs.push_back('{"single",    4, 1,  8'h07, 8'h07, 1});
    vecs.push_back('{"ovf_hi_lo", 5, 2,  8'h80, 8'h7F, 2});
    vecs.push_back('{"ovf_lo_hi", 7, 2,  8'h80, 8'h7F, 2});
    vecs.push_back('{"saturate",  9, 17, 8'h00, 8'h10, 15});

    #2;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count",     32'(bus.out_count), 32'd0);
    chk("rst_min",       32'(bus.out_min),   32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      q = {};
      for (int i = 0; i < vecs[k].len; i++) q.push_back(pool[vecs[k].first + i]);
      run_frame(vecs[k].name, q, vecs[k].emin, vecs[k].emax, vecs[k].ecount, 0);
    end

    // Result held back while a new sample is already waiting
    send(8'd10, 1'b0);
    send(8'd20, 1'b1);
    while (!bus.out_valid) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hFB;
    bus.in_last  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_min",       32'(bus.out_min),   32'd10);
      chk("hold_max",       32'(bus.out_max),   32'd20);
      chk("hold_count",     32'(bus.out_count), 32'd2);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("hold_released", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    send(8'hFF, 1'b1);
    get_result("after_hold", 8'hFB, 8'hFF, 2, 0);

    // Reset while the min-compare of the final sample is in flight
    send(8'd3, 1'b0);
    send(8'd9, 1'b1);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midrst_count",     32'(bus.out_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    q = '{8'd4};
    run_frame("post_rst", q, 8'd4, 8'd4, 1, 0);

    // Random frames against a plain list-based reference
    for (int f = 0; f < 25; f++) begin
      len = $urandom_range(1, 20);
      q = {};
      mn = 127;
      mx = -128;
      for (int i = 0; i < len; i++) begin
        case ($urandom_range(0, 9))
          0: d = 8'h80;
          1: d = 8'h7F;
          2: d = (i > 0) ? q[$urandom_range(0, i - 1)] : 8'h00;
          default: d = 8'($urandom);
        endcase
        q.push_back(d);
        if (int'($signed(d)) < mn) mn = int'($signed(d));
        if (int'($signed(d)) > mx) mx = int'($signed(d));
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_frame("rand", q, 8'(mn), 8'(mx), (len > 15) ? 15 : len, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
